// File: rtl/video_timing_gen_if.sv
// Pixel stream carrying 24-bit RGB plus a start-of-frame tag, ready/valid handshake.
//   iDATA  : {R[23:16], G[15:8], B[7:0]}
//   iSOF   : first pixel of a frame
//   iVALID : iDATA/iSOF valid
//   oREADY : pixel consumed this cycle when iVALID && oREADY
interface video_timing_gen_if;
    logic [23:0] iDATA;
    logic        iSOF;
    logic        iVALID;
    logic        oREADY;

    modport master (output iDATA, iSOF, iVALID, input  oREADY);
    modport slave  (input  iDATA, iSOF, iVALID, output oREADY);
endinterface

// File: rtl/video_timing_gen.sv
// Video timing generator and stream-to-raster adapter.
// Pulls RGB pixels from a ready/valid stream, places them on a programmable
// raster and drives RGB/HS/VS/DE towards the serializer. Tracks frame
// alignment against the SOF tag and reports underruns.
//   iCLK, iRESETn : pixel clock, asynchronous active-low reset
//   s_px          : pixel stream (slave side)
//   iCLR          : synchronous clear of the sticky status flags
//   oRED/oGRN/oBLU, oHS, oVS, oDE : registered video outputs (1 clock latency)
//   oUNDERRUN     : sticky, active pixel needed but none valid while running
//   oMISALIGN     : sticky, SOF tag and raster origin disagreed
module video_timing_gen #(
    parameter int          pH_ACTIVE    = 640,
    parameter int          pH_FP        = 16,
    parameter int          pH_SYNC      = 96,
    parameter int          pH_BP        = 48,
    parameter int          pV_ACTIVE    = 480,
    parameter int          pV_FP        = 10,
    parameter int          pV_SYNC      = 2,
    parameter int          pV_BP        = 33,
    parameter bit          pHS_POL      = 1'b0,
    parameter bit          pVS_POL      = 1'b0,
    parameter logic [23:0] pBLANK_COLOR = 24'h000000
) (
    input  logic                iCLK,
    input  logic                iRESETn,
    video_timing_gen_if.slave   s_px,
    input  logic                iCLR,
    output logic [7:0]          oRED,
    output logic [7:0]          oGRN,
    output logic [7:0]          oBLU,
    output logic                oHS,
    output logic                oVS,
    output logic                oDE,
    output logic                oUNDERRUN,
    output logic                oMISALIGN
);
    localparam int H_TOTAL = pH_ACTIVE + pH_FP + pH_SYNC + pH_BP;
    localparam int V_TOTAL = pV_ACTIVE + pV_FP + pV_SYNC + pV_BP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HW-1:0] H_ACT   = HW'(pH_ACTIVE);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_BEG  = HW'(pH_ACTIVE + pH_FP);
    localparam logic [HW-1:0] HS_LAST = HW'(pH_ACTIVE + pH_FP + pH_SYNC - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(pV_ACTIVE);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_BEG  = VW'(pV_ACTIVE + pV_FP);
    localparam logic [VW-1:0] VS_LAST = VW'(pV_ACTIVE + pV_FP + pV_SYNC - 1);

    typedef enum logic {ST_SYNC = 1'b0, ST_RUN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          de_q, de_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          und_q, und_d;
    logic          mis_q, mis_d;

    logic active, origin, sof_ok, take, und_set, mis_set;

    // Raster counters; V only advances on the H wrap, so VS is line-stable.
    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end
    end

    assign active = (h_q < H_ACT) && (v_q < V_ACT);
    assign origin = (h_q == '0) && (v_q == '0);
    // The tag is correct exactly when it coincides with the raster origin.
    assign sof_ok = (s_px.iSOF == origin);

    always_comb begin
        state_d     = state_q;
        s_px.oREADY = 1'b0;
        take        = 1'b0;
        und_set     = 1'b0;
        mis_set     = 1'b0;
        case (state_q)
            ST_SYNC: begin
                // Drain untagged pixels anywhere; hold an SOF pixel until origin.
                s_px.oREADY = !s_px.iSOF || origin;
                if (origin && s_px.iVALID && s_px.iSOF) begin
                    take    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (active) begin
                    s_px.oREADY = sof_ok;
                    if (!s_px.iVALID) begin
                        // Pixel slips; the next origin check catches it.
                        und_set = 1'b1;
                    end else if (sof_ok) begin
                        take = 1'b1;
                    end else begin
                        mis_set = 1'b1;
                        state_d = ST_SYNC;
                    end
                end
            end
        endcase
    end

    always_comb begin
        de_d  = active;
        hs_d  = (h_q >= HS_BEG && h_q <= HS_LAST) ? pHS_POL : !pHS_POL;
        vs_d  = (v_q >= VS_BEG && v_q <= VS_LAST) ? pVS_POL : !pVS_POL;
        rgb_d = !active ? 24'h000000 : (take ? s_px.iDATA : pBLANK_COLOR);
        // A set in the same cycle as iCLR wins.
        und_d = und_set || (und_q && !iCLR);
        mis_d = mis_set || (mis_q && !iCLR);
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q <= ST_SYNC;
            h_q     <= '0;
            v_q     <= '0;
            de_q    <= 1'b0;
            hs_q    <= !pHS_POL;
            vs_q    <= !pVS_POL;
            rgb_q   <= 24'h000000;
            und_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            rgb_q   <= rgb_d;
            und_q   <= und_d;
            mis_q   <= mis_d;
        end
    end

    assign oRED      = rgb_q[23:16];
    assign oGRN      = rgb_q[15:8];
    assign oBLU      = rgb_q[7:0];
    assign oDE       = de_q;
    assign oHS       = hs_q;
    assign oVS       = vs_q;
    assign oUNDERRUN = und_q;
    assign oMISALIGN = mis_q;
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Pixel-clock video timing generator and stream-to-raster adapter. It pulls 24-bit RGB pixels from an upstream ready/valid stream, such as a framebuffer reader FIFO, and places them on a programmable raster. It produces the RGB, HS, VS and DE signals consumed by the DVI/TMDS serializer stage. It also checks frame alignment using a start-of-frame tag, resynchronizes after a misalignment, and reports underruns.

## Interface
- pH_ACTIVE, 640, active pixels per line
- pH_FP, 16, horizontal front porch (clocks)
- pH_SYNC, 96, HS pulse width
- pH_BP, 48, horizontal back porch
- pV_ACTIVE, 480, active lines per frame
- pV_FP, 10, vertical front porch (lines)
- pV_SYNC, 2, VS pulse width (lines)
- pV_BP, 33, vertical back porch
- pHS_POL, 0, HS asserted level
- pVS_POL, 0, VS asserted level
- pBLANK_COLOR, 24'h000000, RGB emitted when no valid pixel is available
- iCLK  in  1  pixel clock; the only clock
- iRESETn  in  1  asynchronous, active-low reset
- iDATA  in  24  pixel {R[23:16],G[15:8],B[7:0]}
- iSOF  in  1  tags iDATA as the first pixel of a frame
- iVALID  in  1  iDATA/iSOF valid
- oREADY  out  1  pixel consumed this cycle when iVALID&&oREADY
- iCLR  in  1  synchronous clear of status flags
- oRED, oGRN, oBLU  out  8 each  pixel colour
- oHS, oVS, oDE  out  1 each  sync and data enable
- oUNDERRUN  out  1  sticky: active pixel needed, none valid, while in RUN
- oMISALIGN  out  1  sticky: SOF tag and raster origin disagreed

## Operation
- H counter runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H params. Line order is active, FP, sync, BP.
- V counter increments when H wraps and runs 0..V_TOTAL-1 with the same ordering.
- Counters are sized by $clog2 of the total.
- active = h<pH_ACTIVE && v<pV_ACTIVE. origin = h==0 && v==0.
- HS is asserted for h in [pH_ACTIVE+pH_FP, +pH_SYNC). VS is asserted for v in the analogous range. VS changes only on the H wrap.
- The state machine has two states, SYNC and RUN.
- Behaviour in SYNC:
  - oREADY = !iSOF, so untagged pixels are dropped at any raster position. An SOF-tagged pixel is held.
  - At origin, if iVALID&&iSOF: consume the pixel, output it, and go to RUN.
  - Active positions not served from the stream output pBLANK_COLOR. No flag is raised.
- Behaviour in RUN:
  - Outside the active region: oREADY=0.
  - At origin with iVALID&&iSOF: consume the pixel and output it.
  - At origin with iVALID&&!iSOF: do not consume, output blank, set oMISALIGN, go to SYNC.
  - At an active non-origin position with iVALID&&iSOF (early SOF): do not consume, output blank, set oMISALIGN, go to SYNC.
  - At an active position with iVALID&&!iSOF (non-origin): consume the pixel and output it.
  - At an active position with !iVALID: output blank and set oUNDERRUN. The state stays RUN, so the pixel slips; the next origin check catches the resulting misalignment.
- oREADY is combinational from state, counters, iVALID and iSOF. No combinational path exists from iREADY-type inputs, because the block has none.
- Status flags: iCLR clears oUNDERRUN and oMISALIGN. If a set and iCLR occur in the same cycle, the set wins.

## Timing
- Reset values:
  - Counters h=0, v=0; state=SYNC.
  - oDE=0, oRED/oGRN/oBLU=0.
  - oHS=!pHS_POL, oVS=!pVS_POL.
  - oUNDERRUN=0, oMISALIGN=0.
- Asynchronous assertion of reset takes effect immediately, including mid-line. Deassertion restarts the raster at origin on the next clock.
- All outputs except oREADY are registered, with 1 clock latency from the counter value (and the consumed pixel) to oDE/oHS/oVS/RGB. DE, sync and RGB are mutually aligned.
- The pixel accepted in cycle t appears on oRED/oGRN/oBLU in cycle t+1 with oDE=1.
- oDE=0 implies RGB=0. oDE=1 with no pixel consumed implies RGB=pBLANK_COLOR.
- Frame period is exactly H_TOTAL*V_TOTAL clocks. The SYNC→RUN transition is decided only at origin.

## Test plan
Use small timing params: H 4/1/2/1 and V 3/1/1/1 (H_TOTAL=8, V_TOTAL=6).

- Reset, then present a continuous stream with iSOF on every 12th pixel (pixel values = index). Expect:
  - RUN entered at cycle 0.
  - oDE high 4 of every 8 clocks on lines 0-2; oHS asserted at h=5,6; oVS asserted on line 4.
  - RGB equals the index, 1 clock late; no flags set.
- In SYNC, feed 5 untagged pixels, then an SOF pixel mid-frame. Expect:
  - The 5 untagged pixels are dropped (oREADY=1).
  - The SOF pixel is held (oREADY=0) until the next origin, then output with oDE=1.
  - Blank colour on active positions before that; no flags.
- In RUN, deassert iVALID for the 2nd pixel of line 1. Expect pBLANK_COLOR at that position, oUNDERRUN=1, then misalignment detected at the next origin (oMISALIGN=1, state SYNC).
- Present iSOF at h=2,v=1 while in RUN. Expect the pixel not consumed, oMISALIGN=1, SYNC entered, and that pixel output at the following origin.
- Assert iCLR in the same cycle as a new underrun. Expect oUNDERRUN to remain 1. Assert iCLR alone next. Expect both flags 0.
- Assert iRESETn low at h=3,v=1 with oDE high. Expect outputs immediately at reset values, and the raster restarting at origin after release.
